vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
Sink-side counterpart of the SoC VGA timing generator. It samples an incoming HSYNC/VSYNC pair and measures line period, HSYNC width, lines per frame and VSYNC width. It identifies the mode as 640x480 or 800x600, declares lock, and regenerates pixel coordinates plus an active flag. It feeds the frame-capture and self-test logic, and closes the loop on the timing generator in loopback tests.

Parameters:
LOCK_FRAMES, 2, consecutive fully matching frames required before o_locked asserts (1..7)
TIMEOUT, 2047, clocks without an HSYNC falling edge before forced unlock

Ports:
i_clk  in  1  pixel clock (25 MHz or 40 MHz)
i_rst_n  in  1  asynchronous active-low reset
i_hsync  in  1  HSYNC, active-low pulse
i_vsync  in  1  VSYNC, active-low pulse
o_locked  out  1  mode identified and stable
o_mode  out  1  0 = 640x480, 1 = 800x600; valid only while o_locked
o_active  out  1  recovered active region; gated by o_locked
o_px_x  out  10  recovered column; 0 outside the active region
o_px_y  out  10  recovered row; 0 outside the active region
o_frame_start  out  1  one-cycle pulse on each VSYNC falling edge
o_err  out  1  one-cycle pulse on any measured mismatch while locked, or on timeout

Behaviour:
- Reset: one clock, one reset. Reset is asynchronous and active-low. Every register clears, all outputs are 0, and the FSM enters SEARCH.
- Input path: each sync input goes through 2 flops, then an edge-detect register. Edge pulses are therefore 3 cycles after the pin edge. All counts below are in synchronised time.
- hcnt (11b, saturates at 2047):
  - resets to 0 on the cycle after an HSYNC falling edge, otherwise increments;
  - on an HSYNC fall, h_period = hcnt+1 is captured;
  - on an HSYNC rise, h_sync = hcnt+1 is captured.
- vcnt (10b, saturates at 1023):
  - resets to 0 on a VSYNC fall, otherwise increments on each HSYNC fall;
  - on a VSYNC fall, v_total = vcnt is captured;
  - on a VSYNC rise, v_sync = vcnt is captured;
  - if both edges fall in the same cycle, the VSYNC reset wins.
- Mode table (h_period/h_sync/v_total/v_sync/HBP/VBP/HACT/VACT):
  - mode 0: 800/96/525/2/48/33/640/480
  - mode 1: 1056/128/628/4/88/23/800/600
- FSM states: SEARCH, VERIFY, LOCKED.
  - SEARCH: on a VSYNC fall, if the captured set matches a mode exactly, store that mode, set match_cnt=1 and go to VERIFY.
  - VERIFY: on each VSYNC fall, a match against the stored mode increments match_cnt. At match_cnt==LOCK_FRAMES go to LOCKED and assert o_locked. Any mismatch returns to SEARCH with match_cnt=0.
  - LOCKED: h_period and h_sync are checked on every line; v_total and v_sync are checked every frame. A mismatch drops o_locked, pulses o_err and returns to SEARCH, all on the cycle after the capturing edge.
- Timeout: a separate counter clears on each HSYNC fall. When it reaches TIMEOUT in any state, the FSM goes to SEARCH and o_locked clears. o_err pulses only if the FSM was LOCKED.
- Coordinates, while LOCKED, with x = hcnt − (h_sync+HBP) and y = vcnt − (v_sync+VBP):
  - o_active = 1 iff 0 ≤ x < HACT and 0 ≤ y < VACT;
  - o_px_x = x and o_px_y = y when active, else 0;
  - all outputs are registered, one cycle after hcnt.
- o_frame_start pulses on every VSYNC fall, locked or not.
- A mode change mid-frame behaves as a mismatch and relocks after LOCK_FRAMES+1 frames.
- Reset asserted mid-frame clears everything immediately. After release, relock needs a full frame plus LOCK_FRAMES frames.

Test Plan:
- Drive 640x480 timing from the timing generator at 25 MHz for 4 frames -> o_locked rises after the 3rd VSYNC fall, o_mode=0; the first active pixel gives o_px_x=0, o_px_y=0; the last gives 639/479.
- Drive 800x600 timing (i_res=1) for 4 frames -> o_locked with o_mode=1; o_active high for exactly 800 cycles per active line and for 600 lines per frame.
- Once locked in 640x480, stretch one line to 801 clocks -> o_err pulses once, o_locked=0; relock after 3 further clean VSYNC falls.
- Once locked, hold i_hsync high for 2100 clocks -> o_locked clears at timeout count 2047, o_err pulses once, outputs go to 0.
- Pulse i_rst_n low mid-frame while locked -> all outputs 0 asynchronously; no lock until LOCK_FRAMES+1 VSYNC falls after release.
- Feed HSYNC width 97 with otherwise valid 640x480 timing -> never locks, o_frame_start still pulses every frame.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers VGA timing from an incoming HSYNC/VSYNC pair. It measures the line
//   period, HSYNC width, lines per frame and VSYNC width, and identifies
//   640x480 or 800x600. It declares lock after LOCK_FRAMES consecutive matching
//   frames. While locked it regenerates pixel coordinates and an active flag.
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_hsync        HSYNC input, active-low pulse
//   i_vsync        VSYNC input, active-low pulse
//   o_locked       mode identified and stable
//   o_mode         0 = 640x480, 1 = 800x600 (0 while unlocked)
//   o_active       recovered active region (0 while unlocked)
//   o_px_x/o_px_y  recovered column/row, 0 outside the active region
//   o_frame_start  one-cycle pulse per VSYNC falling edge
//   o_err          one-cycle pulse on a mismatch while locked, or on a timeout
module vga_sync_decoder #(
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT     = 2047
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_hsync,
   input  logic       i_vsync,
   output logic       o_locked,
   output logic       o_mode,
   output logic       o_active,
   output logic [9:0] o_px_x,
   output logic [9:0] o_px_y,
   output logic       o_frame_start,
   output logic       o_err
);

   typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

   localparam int            TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

   // Synchroniser plus edge-detect pipeline
   logic hs_meta_q, hs_sync_q, hs_prev_q, hs_fall_q, hs_rise_q;
   logic vs_meta_q, vs_sync_q, vs_prev_q, vs_fall_q, vs_rise_q;

   // Measurement state
   logic [10:0]   hcnt_q, hcnt_d, h_period_q, h_period_d, h_sync_q, h_sync_d;
   logic [9:0]    vcnt_q, vcnt_d, v_total_q, v_total_d, v_sync_q, v_sync_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;

   // FSM state
   state_t     state_q, state_d;
   logic       mode_q, mode_d;
   logic [2:0] match_cnt_q, match_cnt_d;
   logic       armed_q, armed_d;

   // Registered outputs
   logic       locked_q, locked_d, mode_out_q, mode_out_d, active_q, active_d;
   logic [9:0] px_x_q, px_x_d, px_y_q, px_y_d;
   logic       frame_start_q, frame_start_d, err_q, err_d;

   function automatic logic mode_match(input logic m, input logic [10:0] hp,
                                       input logic [10:0] hs, input logic [9:0] vt,
                                       input logic [9:0] vs);
      if (m)
         return (hp == 11'd1056) && (hs == 11'd128) && (vt == 10'd628) && (vs == 10'd4);
      else
         return (hp == 11'd800) && (hs == 11'd96) && (vt == 10'd525) && (vs == 10'd2);
   endfunction

   logic [10:0] hcnt_inc, h_start, h_end, x_full, exp_hp, exp_hs;
   logic [9:0]  vcnt_inc, v_start, v_end, y_full, exp_vt, exp_vs;
   logic [2:0]  match_cnt_inc;
   logic        m0, m1, stored_match, line_bad, frame_bad, timeout, lock_next;

   always_comb begin
      // Saturating increments
      hcnt_inc = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
      vcnt_inc = (vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1;

      hcnt_d     = hs_fall_q ? 11'd0 : hcnt_inc;
      h_period_d = hs_fall_q ? hcnt_inc : h_period_q;
      h_sync_d   = hs_rise_q ? hcnt_inc : h_sync_q;

      // The VSYNC reset takes priority over an HSYNC increment in the same cycle
      vcnt_d = vcnt_q;
      if (vs_fall_q)      vcnt_d = 10'd0;
      else if (hs_fall_q) vcnt_d = vcnt_inc;
      v_total_d = vs_fall_q ? vcnt_q : v_total_q;
      v_sync_d  = vs_rise_q ? vcnt_q : v_sync_q;

      to_cnt_d = hs_fall_q ? '0 : ((to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1);
      timeout  = (to_cnt_q == TO_MAX);

      // Mismatches are judged on the values being captured this cycle, so the
      // FSM reacts on the cycle right after the capturing edge.
      m0            = mode_match(1'b0, h_period_d, h_sync_d, v_total_d, v_sync_d);
      m1            = mode_match(1'b1, h_period_d, h_sync_d, v_total_d, v_sync_d);
      stored_match  = mode_q ? m1 : m0;
      exp_hp        = mode_q ? 11'd1056 : 11'd800;
      exp_hs        = mode_q ? 11'd128  : 11'd96;
      exp_vt        = mode_q ? 10'd628  : 10'd525;
      exp_vs        = mode_q ? 10'd4    : 10'd2;
      line_bad      = (hs_fall_q && (h_period_d != exp_hp)) || (hs_rise_q && (h_sync_d != exp_hs));
      frame_bad     = (vs_fall_q && (v_total_d != exp_vt)) || (vs_rise_q && (v_sync_d != exp_vs));
      match_cnt_inc = match_cnt_q + 3'd1;

      state_d     = state_q;
      mode_d      = mode_q;
      match_cnt_d = match_cnt_q;
      armed_d     = armed_q;
      err_d       = 1'b0;

      // armed_q marks that the frame now ending was observed from its start.
      // A frame cut short by reset, timeout or a mid-frame mismatch is never
      // trusted, so relock always takes one full frame plus LOCK_FRAMES frames.
      unique case (state_q)
         ST_SEARCH: begin
            if (vs_fall_q) begin
               armed_d = 1'b1;
               if (armed_q && (m0 || m1)) begin
                  mode_d      = m1;
                  match_cnt_d = 3'd1;
                  state_d     = (LOCK_FRAMES <= 1) ? ST_LOCKED : ST_VERIFY;
               end
            end
         end
         ST_VERIFY: begin
            if (vs_fall_q) begin
               if (stored_match) begin
                  match_cnt_d = match_cnt_inc;
                  if (int'(match_cnt_inc) >= LOCK_FRAMES) state_d = ST_LOCKED;
               end else begin
                  match_cnt_d = 3'd0;
                  state_d     = ST_SEARCH;
               end
            end
         end
         ST_LOCKED: begin
            if (line_bad || frame_bad) begin
               state_d     = ST_SEARCH;
               match_cnt_d = 3'd0;
               err_d       = 1'b1;
               armed_d     = vs_fall_q;   // a frame boundary starts a clean frame
            end
         end
         default: state_d = ST_SEARCH;
      endcase

      if (timeout) begin
         state_d     = ST_SEARCH;
         match_cnt_d = 3'd0;
         armed_d     = 1'b0;
         err_d       = (state_q == ST_LOCKED);
      end

      // Coordinates are gated by the next lock state so o_active never
      // outlives o_locked by a cycle.
      lock_next = (state_d == ST_LOCKED);
      h_start   = mode_d ? 11'd216  : 11'd144;
      h_end     = mode_d ? 11'd1016 : 11'd784;
      v_start   = mode_d ? 10'd27   : 10'd35;
      v_end     = mode_d ? 10'd627  : 10'd515;
      x_full    = hcnt_q - h_start;
      y_full    = vcnt_q - v_start;

      active_d      = lock_next && (hcnt_q >= h_start) && (hcnt_q < h_end) &&
                      (vcnt_q >= v_start) && (vcnt_q < v_end);
      px_x_d        = active_d ? x_full[9:0] : 10'd0;
      px_y_d        = active_d ? y_full : 10'd0;
      locked_d      = lock_next;
      mode_out_d    = lock_next && mode_d;
      frame_start_d = vs_fall_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_meta_q <= 1'b0; hs_sync_q <= 1'b0; hs_prev_q <= 1'b0;
         hs_fall_q <= 1'b0; hs_rise_q <= 1'b0;
         vs_meta_q <= 1'b0; vs_sync_q <= 1'b0; vs_prev_q <= 1'b0;
         vs_fall_q <= 1'b0; vs_rise_q <= 1'b0;
         hcnt_q <= '0; h_period_q <= '0; h_sync_q <= '0;
         vcnt_q <= '0; v_total_q <= '0; v_sync_q <= '0;
         to_cnt_q <= '0;
         state_q <= ST_SEARCH; mode_q <= 1'b0; match_cnt_q <= '0; armed_q <= 1'b0;
         locked_q <= 1'b0; mode_out_q <= 1'b0; active_q <= 1'b0;
         px_x_q <= '0; px_y_q <= '0; frame_start_q <= 1'b0; err_q <= 1'b0;
      end else begin
         hs_meta_q <= i_hsync;   hs_sync_q <= hs_meta_q;  hs_prev_q <= hs_sync_q;
         hs_fall_q <= hs_prev_q & ~hs_sync_q;
         hs_rise_q <= ~hs_prev_q & hs_sync_q;
         vs_meta_q <= i_vsync;   vs_sync_q <= vs_meta_q;  vs_prev_q <= vs_sync_q;
         vs_fall_q <= vs_prev_q & ~vs_sync_q;
         vs_rise_q <= ~vs_prev_q & vs_sync_q;
         hcnt_q <= hcnt_d; h_period_q <= h_period_d; h_sync_q <= h_sync_d;
         vcnt_q <= vcnt_d; v_total_q <= v_total_d; v_sync_q <= v_sync_d;
         to_cnt_q <= to_cnt_d;
         state_q <= state_d; mode_q <= mode_d; match_cnt_q <= match_cnt_d; armed_q <= armed_d;
         locked_q <= locked_d; mode_out_q <= mode_out_d; active_q <= active_d;
         px_x_q <= px_x_d; px_y_q <= px_y_d; frame_start_q <= frame_start_d; err_q <= err_d;
      end
   end

   assign o_locked      = locked_q;
   assign o_mode        = mode_out_q;
   assign o_active      = active_q;
   assign o_px_x        = px_x_q;
   assign o_px_y        = px_y_q;
   assign o_frame_start = frame_start_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Directed bench for vga_sync_decoder: drives complete 640x480 and 800x600
//   frames (VSYNC edges placed 8 pixels after the HSYNC fall of a line) and
//   checks lock timing, recovered coordinates, error pulses, timeout and reset.
module tb_vga_sync_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hsync = 1'b1;
   logic       vsync = 1'b1;
   logic       locked, mode, active, frame_start, err;
   logic [9:0] px_x, px_y;

   int errors = 0;
   int checks = 0;

   always #20 clk = ~clk;

   vga_sync_decoder dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
      .o_locked(locked), .o_mode(mode), .o_active(active),
      .o_px_x(px_x), .o_px_y(px_y), .o_frame_start(frame_start), .o_err(err)
   );

   // Output observer: pulse counters plus per-frame active-region statistics
   logic       stats_clr = 1'b0;
   int         fs_cnt = 0, err_cnt = 0;
   int         act_total = 0, line_cnt = 0, run_len = 0, run_min = 0, run_max = 0, stray = 0;
   logic       prev_active = 1'b0, got_first = 1'b0;
   logic [9:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;

   always @(negedge clk) begin
      if (frame_start) fs_cnt <= fs_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (stats_clr) begin
         act_total <= 0; line_cnt <= 0; run_len <= 0; run_min <= 1 << 30; run_max <= 0;
         stray <= 0; prev_active <= 1'b0; got_first <= 1'b0;
      end else begin
         if (active) begin
            if (!got_first) begin
               first_x <= px_x; first_y <= px_y; got_first <= 1'b1;
            end
            last_x <= px_x; last_y <= px_y;
            act_total <= act_total + 1;
            run_len <= run_len + 1;
         end else begin
            if (prev_active) begin
               line_cnt <= line_cnt + 1;
               if (run_len < run_min) run_min <= run_len;
               if (run_len > run_max) run_max <= run_len;
               run_len <= 0;
            end
            if (px_x != 10'd0 || px_y != 10'd0) stray <= stray + 1;
         end
         prev_active <= active;
      end
   end

   // One frame of sync timing. hsw_ovr > 0 overrides the HSYNC width,
   // stretch_line gets one extra clock, clr restarts the active statistics.
   task automatic drive_frame(input logic m, input int hsw_ovr, input int stretch_line,
                              input logic clr);
      int hp, hsw, vt, vsw, len;
      hp  = m ? 1056 : 800;
      hsw = (hsw_ovr > 0) ? hsw_ovr : (m ? 128 : 96);
      vt  = m ? 628 : 525;
      vsw = m ? 4 : 2;
      for (int ln = 0; ln < vt; ln++) begin
         len = (ln == stretch_line) ? hp + 1 : hp;
         for (int p = 0; p < len; p++) begin
            @(negedge clk);
            hsync = (p < hsw) ? 1'b0 : 1'b1;
            vsync = ((ln < vsw && p >= 8) || (ln >= 1 && ln <= vsw && p < 8)) ? 1'b0 : 1'b1;
            if (clr) stats_clr = (ln == 0 && p < 2);
         end
      end
      $display("frame mode=%0d locked=%0b o_mode=%0b frame_starts=%0d errs=%0d",
               m, locked, mode, fs_cnt, err_cnt);
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b want 0", mode); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
      checks++; if (px_x !== 10'd0) begin errors++; $display("FAIL reset_px_x: got %0d want 0", px_x); end
      checks++; if (px_y !== 10'd0) begin errors++; $display("FAIL reset_px_y: got %0d want 0", px_y); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic check_frame_stats(input string tag, input int hact, input int vact);
      checks++; if (act_total != hact * vact) begin errors++; $display("FAIL %s_active_total: got %0d want %0d", tag, act_total, hact * vact); end
      checks++; if (line_cnt != vact) begin errors++; $display("FAIL %s_active_lines: got %0d want %0d", tag, line_cnt, vact); end
      checks++; if (run_min != hact || run_max != hact) begin errors++; $display("FAIL %s_line_len: got %0d..%0d want %0d", tag, run_min, run_max, hact); end
      checks++; if (first_x !== 10'd0 || first_y !== 10'd0) begin errors++; $display("FAIL %s_first_px: got %0d/%0d want 0/0", tag, first_x, first_y); end
      checks++; if (int'(last_x) != hact - 1 || int'(last_y) != vact - 1) begin errors++; $display("FAIL %s_last_px: got %0d/%0d want %0d/%0d", tag, last_x, last_y, hact - 1, vact - 1); end
      checks++; if (stray != 0) begin errors++; $display("FAIL %s_px_outside_active: got %0d want 0", tag, stray); end
   endtask

   task automatic test_lock_640();
      int f0;
      f0 = fs_cnt;
      drive_frame(1'b0, 0, -1, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock640_fall1: got %b want 0", locked); end
      drive_frame(1'b0, 0, -1, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock640_fall2: got %b want 0", locked); end
      drive_frame(1'b0, 0, -1, 1'b1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock640_fall3: got %b want 1", locked); end
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL lock640_mode: got %b want 0", mode); end
      checks++; if (fs_cnt - f0 != 3) begin errors++; $display("FAIL lock640_frame_starts: got %0d want 3", fs_cnt - f0); end
      check_frame_stats("lock640", 640, 480);
   endtask

   task automatic test_stretch();
      int e0;
      e0 = err_cnt;
      drive_frame(1'b0, 0, 100, 1'b0);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL stretch_err_pulses: got %0d want 1", err_cnt - e0); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL stretch_unlock: got %b want 0", locked); end
      for (int f = 1; f <= 3; f++) begin
         drive_frame(1'b0, 0, -1, 1'b0);
         checks++;
         if (locked !== (f == 3)) begin
            errors++; $display("FAIL stretch_relock_fall%0d: got %b want %b", f, locked, f == 3);
         end
      end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL stretch_err_total: got %0d want 1", err_cnt - e0); end
   endtask

   task automatic test_reset_midframe();
      fork
         drive_frame(1'b0, 0, -1, 1'b0);
         begin
            repeat (200 * 800 + 300) @(negedge clk);
            checks++; if (active !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL midrst_pre_active: got %b/%b want 1/1", active, locked); end
            #2 rst_n = 1'b0;
            #1;
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %b want 0", locked); end
            checks++; if (active !== 1'b0) begin errors++; $display("FAIL midrst_active: got %b want 0", active); end
            checks++; if (px_x !== 10'd0 || px_y !== 10'd0) begin errors++; $display("FAIL midrst_px: got %0d/%0d want 0/0", px_x, px_y); end
            checks++; if (mode !== 1'b0 || err !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got %b%b%b want 000", mode, err, frame_start); end
            repeat (8) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      for (int f = 1; f <= 3; f++) begin
         drive_frame(1'b0, 0, -1, 1'b0);
         checks++;
         if (locked !== (f == 3)) begin
            errors++; $display("FAIL midrst_relock_fall%0d: got %b want %b", f, locked, f == 3);
         end
      end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_cnt;
      hsync = 1'b1; vsync = 1'b1;
      repeat (1240) @(negedge clk);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b want 1", locked); end
      repeat (20) @(negedge clk);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_unlock: got %b want 0", locked); end
      repeat (840) @(negedge clk);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_err_pulses: got %0d want 1", err_cnt - e0); end
      checks++; if (active !== 1'b0 || mode !== 1'b0) begin errors++; $display("FAIL timeout_outputs: got %b/%b want 0/0", active, mode); end
      checks++; if (px_x !== 10'd0 || px_y !== 10'd0) begin errors++; $display("FAIL timeout_px: got %0d/%0d want 0/0", px_x, px_y); end
      $display("hsync held high 2100 clocks locked=%0b errs=%0d", locked, err_cnt);
   endtask

   task automatic test_lock_800();
      drive_frame(1'b1, 0, -1, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock800_fall1: got %b want 0", locked); end
      drive_frame(1'b1, 0, -1, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock800_fall2: got %b want 0", locked); end
      drive_frame(1'b1, 0, -1, 1'b1);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock800_fall3: got %b want 1", locked); end
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL lock800_mode: got %b want 1", mode); end
      check_frame_stats("lock800", 800, 600);
   endtask

   task automatic test_bad_hsync();
      int f0, e0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      f0 = fs_cnt; e0 = err_cnt;
      for (int f = 1; f <= 3; f++) begin
         drive_frame(1'b0, 97, -1, 1'b0);
         checks++; if (locked !== 1'b0) begin errors++; $display("FAIL badhs_locked_fall%0d: got %b want 0", f, locked); end
      end
      checks++; if (fs_cnt - f0 != 3) begin errors++; $display("FAIL badhs_frame_starts: got %0d want 3", fs_cnt - f0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL badhs_err_pulses: got %0d want 0", err_cnt - e0); end
   endtask

   initial begin
      test_reset();
      test_lock_640();
      test_stretch();
      test_reset_midframe();
      test_timeout();
      test_lock_800();
      test_bad_hsync();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
